// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single 64-bit PVR VRAM port between three requesters:
//   requester 0 : rasterizer (ISP/TSP fetch)
//   requester 1 : TA texture / YUV writes (CS4)
//   requester 2 : SH4 direct VRAM access (CS1 64/32-bit windows)
//
// Round-robin arbitration with a single outstanding transaction. Every
// transaction walks IDLE -> ISSUE -> WAIT -> DONE, so the port is occupied
// for at least four cycles. A programmable timeout forces completion (with
// err) when the memory never returns vram_ack.
//
// Ports
//   clock, reset_n      : clock (rising edge), asynchronous active-low reset
//   req[2:0]            : request level, bit n = requester n
//   we[2:0]             : 1 = write, 0 = read, per requester
//   addr[3*ADDR_W-1:0]  : packed addresses, requester n at [n*ADDR_W +: ADDR_W]
//   wdata[191:0]        : packed write data, 64 bits per requester
//   wmask[23:0]         : packed byte masks, 8 bits per requester
//   ack[2:0]            : one-cycle completion pulse to the owner
//   rdata[63:0]         : read data, valid while ack is nonzero
//   err                 : one-cycle pulse with ack when the access timed out
//   grant[2:0]          : one-hot owner of the current transaction, 0 if idle
//   vram_rd / vram_wr   : one-cycle memory strobes
//   vram_addr/dout/mask : transaction address, write data, byte mask
//   vram_din, vram_ack  : memory read data and completion pulse
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [191:0]          wdata,
    input  logic [23:0]           wmask,
    output logic [2:0]            ack,
    output logic [63:0]           rdata,
    output logic                  err,
    output logic [2:0]            grant,
    output logic                  vram_rd,
    output logic                  vram_wr,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [63:0]           vram_dout,
    output logic [7:0]            vram_mask,
    input  logic [63:0]           vram_din,
    input  logic                  vram_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [1:0]          last_q,       last_d;
    logic                after_done_q, after_done_d;
    logic [1:0]          owner_q,      owner_d;
    logic [2:0]          grant_q,      grant_d;
    logic                we_q,         we_d;
    logic [ADDR_W-1:0]   vram_addr_q,  vram_addr_d;
    logic [63:0]         vram_dout_q,  vram_dout_d;
    logic [7:0]          vram_mask_q,  vram_mask_d;
    logic                vram_rd_q,    vram_rd_d;
    logic                vram_wr_q,    vram_wr_d;
    logic [7:0]          cnt_q,        cnt_d;
    logic [2:0]          ack_q,        ack_d;
    logic                err_q,        err_d;
    logic [63:0]         rdata_q,      rdata_d;

    // -----------------------------------------------------------------------
    // Unpack the per-requester buses and build the eligibility vector
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_arr  [3];
    logic [63:0]       wdata_arr [3];
    logic [7:0]        wmask_arr [3];
    logic [2:0]        last_oh;
    logic [2:0]        eligible;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata[gi*64 +: 64];
            assign wmask_arr[gi] = wmask[gi*8 +: 8];
            assign last_oh[gi]   = (last_q == 2'(gi));
            // The previous winner sits out only the first IDLE cycle after
            // its DONE, which gives it one cycle to drop req after ack.
            assign eligible[gi]  = req[gi] & ~(after_done_q & last_oh[gi]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin winner: scan last+1, last+2, last+3 (mod 3)
    // -----------------------------------------------------------------------
    function automatic logic [1:0] rr_index(input logic [1:0] base,
                                            input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] scan_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            scan_idx = rr_index(last_q, 2'(k));
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Winner's request fields
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [63:0]       sel_wdata;
    logic [7:0]        sel_wmask;

    always_comb begin
        case (win_idx)
            2'd0: begin
                sel_we    = we[0];
                sel_addr  = addr_arr[0];
                sel_wdata = wdata_arr[0];
                sel_wmask = wmask_arr[0];
            end
            2'd1: begin
                sel_we    = we[1];
                sel_addr  = addr_arr[1];
                sel_wdata = wdata_arr[1];
                sel_wmask = wmask_arr[1];
            end
            default: begin
                sel_we    = we[2];
                sel_addr  = addr_arr[2];
                sel_wdata = wdata_arr[2];
                sel_wmask = wmask_arr[2];
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        after_done_d = 1'b0;
        owner_d      = owner_q;
        grant_d      = grant_q;
        we_d         = we_q;
        vram_addr_d  = vram_addr_q;
        vram_dout_d  = vram_dout_q;
        vram_mask_d  = vram_mask_q;
        vram_rd_d    = 1'b0;
        vram_wr_d    = 1'b0;
        cnt_d        = cnt_q;
        ack_d        = 3'b000;
        err_d        = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    owner_d     = win_idx;
                    grant_d     = 3'b001 << win_idx;
                    we_d        = sel_we;
                    vram_addr_d = sel_addr;
                    vram_dout_d = sel_wdata;
                    vram_mask_d = sel_wmask;
                    // Strobe is registered here so it is high during ISSUE.
                    vram_rd_d   = ~sel_we;
                    vram_wr_d   = sel_we;
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (vram_ack) begin
                    // A late ack on the timeout cycle still wins.
                    if (!we_q) begin
                        rdata_d = vram_din;
                    end
                    ack_d   = grant_q;
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    rdata_d = 64'd0;
                    err_d   = 1'b1;
                    ack_d   = grant_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                // ack/err flops are high during this cycle.
                last_d       = owner_q;
                after_done_d = 1'b1;
                grant_d      = 3'b000;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 2'd2;     // first scan order is 0, 1, 2
            after_done_q <= 1'b0;
            owner_q      <= 2'd0;
            grant_q      <= 3'b000;
            we_q         <= 1'b0;
            vram_addr_q  <= '0;
            vram_dout_q  <= 64'd0;
            vram_mask_q  <= 8'd0;
            vram_rd_q    <= 1'b0;
            vram_wr_q    <= 1'b0;
            cnt_q        <= 8'd0;
            ack_q        <= 3'b000;
            err_q        <= 1'b0;
            rdata_q      <= 64'd0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            after_done_q <= after_done_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            vram_addr_q  <= vram_addr_d;
            vram_dout_q  <= vram_dout_d;
            vram_mask_q  <= vram_mask_d;
            vram_rd_q    <= vram_rd_d;
            vram_wr_q    <= vram_wr_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign grant     = grant_q;
    assign vram_rd   = vram_rd_q;
    assign vram_wr   = vram_wr_q;
    assign vram_addr = vram_addr_q;
    assign vram_dout = vram_dout_q;
    assign vram_mask = vram_mask_q;

endmodule
